// File: rtl/noc_input_port.sv
// Router input port: a flit FIFO, a YX route lookup on the head flit, and a wormhole
// lock that keeps the packet's output direction until its tail has gone through.

module yx_processor #(
  parameter logic [7:0] ROUTER_ADDR = 8'h00
) (
  input  logic [7:0] dest_i,
  output logic [2:0] dir_o
);
  // Y is resolved first. Y grows southward and X grows eastward.
  always_comb begin
    dir_o = 3'b100;
    if (dest_i[3:0] > ROUTER_ADDR[3:0])      dir_o = 3'b001;
    else if (dest_i[3:0] < ROUTER_ADDR[3:0]) dir_o = 3'b000;
    else if (dest_i[7:4] > ROUTER_ADDR[7:4]) dir_o = 3'b011;
    else if (dest_i[7:4] < ROUTER_ADDR[7:4]) dir_o = 3'b010;
  end
endmodule

module noc_input_port #(
  parameter int         FLIT_W      = 34,
  parameter int         DEPTH       = 4,
  parameter logic [7:0] ROUTER_ADDR = 8'h00
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [FLIT_W-1:0]          in_flit_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic                       out_req_o,
  output logic [2:0]                 out_dir_o,
  input  logic                       out_gnt_i,
  output logic [FLIT_W-1:0]          out_flit_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       err_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ROUTE, ACTIVE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        dir_q, dir_d;
  logic              err_q, err_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [FLIT_W-1:0] mem_q [DEPTH];

  logic              wr_en, rd_en, drop, not_empty;
  logic [FLIT_W-1:0] head;
  logic [1:0]        head_type;
  logic [2:0]        route_dir;

  assign head       = mem_q[rd_ptr_q];
  assign head_type  = head[FLIT_W-1 -: 2];
  assign not_empty  = (count_q != '0);
  // Ready depends only on registered occupancy, so nothing downstream reaches it.
  assign in_ready_o = (count_q != CW'(DEPTH));
  assign wr_en      = in_valid_i & in_ready_o;
  assign rd_en      = (out_valid_o & out_ready_i) | drop;

  yx_processor #(.ROUTER_ADDR(ROUTER_ADDR)) u_yx (
    .dest_i (head[7:0]),
    .dir_o  (route_dir)
  );

  always_comb begin
    wr_ptr_d = wr_en ? PW'(wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = rd_en ? PW'(rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d  = count_q + CW'(wr_en) - CW'(rd_en);
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    err_d       = 1'b0;
    drop        = 1'b0;
    out_req_o   = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (not_empty) begin
          // type[0] set means head or head+tail; anything else is an orphan
          if (head_type[0]) begin
            state_d = ROUTE;
            dir_d   = route_dir;
          end else begin
            drop  = 1'b1;
            err_d = 1'b1;
          end
        end
      end
      ROUTE: begin
        out_req_o = 1'b1;
        if (out_gnt_i) state_d = ACTIVE;
      end
      ACTIVE: begin
        out_req_o   = 1'b1;
        out_valid_o = not_empty & out_gnt_i;
        if (out_valid_o && out_ready_i && head_type[1]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      dir_q    <= 3'b000;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_flit_i;
  end

  assign out_dir_o  = dir_q;
  assign out_flit_o = head;
  assign count_o    = count_q;
  assign err_o      = err_q;
endmodule
